key_scan_ctrl: RTL and testbench
================================

// Module: key_scan_ctrl
// PURPOSE
//   Scan sequencer and debouncer for the 4x4 matrix keypad. Drives one column low at
//   a time, samples the row lines and debounces a single pressed key. Emits a one-cycle
//   key_valid strobe with the latched {code_c, code_r} pair, which feeds key2num's
//   {KEY_C, KEY_R} inputs to produce ins_num.
// PARAMETERS
//   SCAN_DIV        50000  clocks per column dwell (>=2); rows sampled on last dwell cycle
//   DEBOUNCE_SCANS  4      consecutive identical samples needed to accept press/release (>=1)
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst        in   1  synchronous, active-high reset
//   KEY_R      in   4  keypad row lines, pulled up; a pressed key on the driven column pulls its row low
//   KEY_C      out  4  keypad column drive, one-hot-low
//   code_c     out  4  latched column pattern of accepted key (to key2num KEY_C)
//   code_r     out  4  latched row pattern of accepted key (to key2num KEY_R)
//   key_valid  out  1  one-cycle strobe, new key accepted; code_* valid from this cycle on
//   key_down   out  1  level, high while the accepted key is held
// BEHAVIOUR
//   Reset (sync, rst=1 at a clock edge): state=SCAN, col_idx=0, div=0, KEY_C=4'b0111,
//     code_c=code_r=4'b1111, key_valid=0, key_down=0, debounce/release counters=0.
//   Column map: col_idx 0->0111, 1->1011, 2->1101, 3->1110; wraps 3->0.
//   Divider: div counts 0..SCAN_DIV-1 and wraps; tick = (div==SCAN_DIV-1). Free-runs in all states.
//     First tick after reset release falls on the SCAN_DIV-th clock.
//   Row sample valid: KEY_R has exactly one bit low. 4'b1111 = none. >=2 bits low = ghost/multi,
//     treated as none.
//   SCAN: on tick, with a valid sample: capture cand_c=KEY_C, cand_r=KEY_R, set cnt=1.
//     If DEBOUNCE_SCANS==1, go straight to PRESSED (accept). Otherwise go to DEBOUNCE and
//     hold the column.
//     On tick with no valid sample: col_idx++ (KEY_C changes on the next clock).
//   DEBOUNCE: column held. On tick: KEY_R==cand_r -> cnt++; when cnt reaches DEBOUNCE_SCANS,
//     accept. Mismatch (including 1111 or multi-row) -> SCAN, col_idx++, cnt=0.
//   Accept: registered outputs on the clock after the accepting tick: code_c<=cand_c,
//     code_r<=cand_r, key_valid=1 for exactly 1 cycle, key_down<=1; state=PRESSED.
//   PRESSED: column held. rel_cnt counts consecutive ticks with KEY_R==4'b1111; any other
//     sample clears rel_cnt. When rel_cnt reaches DEBOUNCE_SCANS: key_down<=0, col_idx++,
//     state=SCAN. A different row or a second key while held never produces a new key_valid.
//   Latency: from the first detecting tick to key_valid = (DEBOUNCE_SCANS-1)*SCAN_DIV + 1 clocks.
//   code_c/code_r hold their last accepted value until the next accept or reset.
//   rst mid-DEBOUNCE/PRESSED: full reset values next cycle. A key still held after reset needs
//     a fresh full debounce before its key_valid.
//   Counters saturate-free by construction: cnt and rel_cnt never exceed DEBOUNCE_SCANS.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=3; keypad model pulls row low only while its column is driven)
//   1 Reset/rotation: rst=1 for 2 clks, no key -> KEY_C=0111, code_*=1111, valid/down=0;
//     KEY_C steps 0111->1011->1101->1110->0111 every 4 clks, first change 4 clks after release.
//   2 Press key 5 (C=1011, R=1011), held -> KEY_C frozen at 1011; one key_valid 9 clks after
//     the detecting tick; code_c=1011, code_r=1011 (key2num=5); key_down=1.
//   3 Bounce: row low for 2 ticks, then 1111 -> no key_valid, key_down=0, rotation resumes at 1101.
//   4 Release after test 2: KEY_R=1111 for 2 ticks, low 1 tick, then 1111 for 3 ticks -> key_down
//     falls only after the final 3; no extra key_valid; code_* still 1011/1011.
//   5 Multi-key: KEY_R=1001 on column 0111 for 10 ticks -> no key_valid, rotation continues.
//   6 rst pulse while PRESSED with the key still held -> reset values next clk; a fresh key_valid
//     appears only after 3 matching ticks.

Source files
------------

// File: rtl/key_scan_ctrl.sv
// 4x4 keypad scanner: rotates a one-hot-low column drive, debounces a single pressed key
// and reports it as a latched {code_c, code_r} pair with a one-cycle key_valid strobe.
module key_scan_ctrl #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] KEY_R,
    output logic [3:0] KEY_C,
    output logic [3:0] code_c,
    output logic [3:0] code_r,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        ACCEPT,
        PRESSED
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div;
    logic [1:0]       col_idx, col_idx_n;
    logic [3:0]       cand_c, cand_c_n;
    logic [3:0]       cand_r, cand_r_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [CNT_W-1:0] rel_cnt, rel_cnt_n, rel_inc;
    logic [3:0]       code_c_n, code_r_n;
    logic             key_valid_n, key_down_n;
    logic             tick;
    logic             row_valid;

    assign tick      = (div == DIV_LAST);
    assign row_valid = ($countones(~KEY_R) == 1);
    assign cnt_inc   = cnt + CNT_W'(1);
    assign rel_inc   = rel_cnt + CNT_W'(1);
    assign KEY_C     = ~(4'b1000 >> col_idx);

    // The dwell divider free-runs regardless of FSM state so column timing never slips.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || tick) div <= '0;
        else             div <= div + DIV_W'(1);
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_n     = state;
        col_idx_n   = col_idx;
        cand_c_n    = cand_c;
        cand_r_n    = cand_r;
        cnt_n       = cnt;
        rel_cnt_n   = rel_cnt;
        code_c_n    = code_c;
        code_r_n    = code_r;
        key_valid_n = 1'b0;
        key_down_n  = key_down;

        case (state)
            SCAN: if (tick) begin
                if (row_valid) begin
                    cand_c_n = KEY_C;
                    cand_r_n = KEY_R;
                    cnt_n    = CNT_W'(1);
                    state_n  = (DEBOUNCE_SCANS == 1) ? ACCEPT : DEBOUNCE;
                end else begin
                    col_idx_n = col_idx + 2'd1;
                end
            end
            DEBOUNCE: if (tick) begin
                if (KEY_R == cand_r) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CNT_DONE) state_n = ACCEPT;
                end else begin
                    cnt_n     = '0;
                    col_idx_n = col_idx + 2'd1;
                    state_n   = SCAN;
                end
            end
            // One extra cycle so the accepted pair is presented a clock after the deciding tick.
            ACCEPT: begin
                code_c_n    = cand_c;
                code_r_n    = cand_r;
                key_valid_n = 1'b1;
                key_down_n  = 1'b1;
                cnt_n       = '0;
                rel_cnt_n   = '0;
                state_n     = PRESSED;
            end
            PRESSED: if (tick) begin
                if (KEY_R == 4'b1111) begin
                    if (rel_inc == CNT_DONE) begin
                        rel_cnt_n  = '0;
                        key_down_n = 1'b0;
                        col_idx_n  = col_idx + 2'd1;
                        state_n    = SCAN;
                    end else begin
                        rel_cnt_n = rel_inc;
                    end
                end else begin
                    rel_cnt_n = '0;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            col_idx   <= '0;
            cand_c    <= 4'b1111;
            cand_r    <= 4'b1111;
            cnt       <= '0;
            rel_cnt   <= '0;
            code_c    <= 4'b1111;
            code_r    <= 4'b1111;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= col_idx_n;
            cand_c    <= cand_c_n;
            cand_r    <= cand_r_n;
            cnt       <= cnt_n;
            rel_cnt   <= rel_cnt_n;
            code_c    <= code_c_n;
            code_r    <= code_r_n;
            key_valid <= key_valid_n;
            key_down  <= key_down_n;
        end
    end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl: vector table, directed multi-cycle corner cases and randomized
// key activity checked every cycle against a tick-level keypad reference model.
`timescale 1ns/1ps
module tb_key_scan_ctrl;

    localparam int SD = 4;
    localparam int DB = 3;
    // keys bit 4*c+r set = key on column-bit c / row-bit r is pressed
    localparam logic [15:0] K_NONE  = 16'h0000;
    localparam logic [15:0] K5      = 16'h0400;
    localparam logic [15:0] K_MULTI = 16'h6000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  key_r, key_c, code_c, code_r;
    logic        key_valid, key_down;

    int n_chk  = 0;
    int n_err  = 0;
    int vcount = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] rows_low(input logic [3:0] kc, input logic [15:0] k);
        logic [3:0] res;
        res = 4'b0000;
        for (int c = 0; c < 4; c++)
            if (!kc[c]) res = res | k[4*c +: 4];
        return res;
    endfunction

    assign key_r = ~rows_low(key_c, keys);

    key_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .KEY_R     (key_r),
        .KEY_C     (key_c),
        .code_c    (code_c),
        .code_r    (code_r),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: works per scan tick, keeping the run of identical samples in a queue.
    initial begin : model
        int         m_div, m_col, m_rel;
        logic [3:0] m_cand_c, m_cand_r, m_code_c, m_code_r, s;
        logic       m_valid, m_down, m_pend, m_armed, tick, r;
        logic [3:0] hist[$];
        logic [3:0] col_pat [4];
        col_pat = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        m_armed = 1'b0;
        m_div = 0; m_col = 0; m_rel = 0;
        m_cand_c = 4'hF; m_cand_r = 4'hF; m_code_c = 4'hF; m_code_r = 4'hF;
        m_valid = 1'b0; m_down = 1'b0; m_pend = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            s = key_r;
            r = rst;
            @(posedge clk);
            if (r) begin
                m_armed = 1'b1;
                m_div = 0; m_col = 0; m_rel = 0;
                m_code_c = 4'hF; m_code_r = 4'hF;
                m_valid = 1'b0; m_down = 1'b0; m_pend = 1'b0;
                hist.delete();
            end else begin
                tick    = (m_div == SD - 1);
                m_div   = (m_div + 1) % SD;
                m_valid = 1'b0;
                if (m_pend) begin
                    m_code_c = m_cand_c; m_code_r = m_cand_r;
                    m_valid = 1'b1; m_down = 1'b1; m_pend = 1'b0; m_rel = 0;
                end else if (tick) begin
                    if (m_down) begin
                        m_rel = (s == 4'b1111) ? m_rel + 1 : 0;
                        if (m_rel == DB) begin
                            m_down = 1'b0; m_rel = 0; m_col = (m_col + 1) % 4;
                        end
                    end else if (hist.size() != 0 && s != hist[0]) begin
                        hist.delete();
                        m_col = (m_col + 1) % 4;
                    end else if (hist.size() == 0 &&
                                 !(s inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) begin
                        m_col = (m_col + 1) % 4;
                    end else begin
                        hist.push_back(s);
                        if (hist.size() == DB) begin
                            m_cand_c = col_pat[m_col]; m_cand_r = s; m_pend = 1'b1;
                            hist.delete();
                        end
                    end
                end
            end
            #1;
            if (key_valid === 1'b1) vcount++;
            if (m_armed)
                check("model", {18'd0, key_c, code_c, code_r, key_valid, key_down},
                       {18'd0, col_pat[m_col], m_code_c, m_code_r, m_valid, m_down});
        end
    end

    typedef struct {
        bit          rst_first;
        int          k;
        logic [15:0] keys_after;
        logic [3:0]  kc, cc, cr;
        logic        v, d;
    } vec_t;

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stim
        vec_t vecs [18];
        int   k, v0, lat, sel, dur, a, b;

        vecs[0]  = '{1'b1,  0, K_NONE, 4'b0111, 4'hF, 4'hF, 1'b0, 1'b0};
        vecs[1]  = '{1'b0,  3, K_NONE, 4'b0111, 4'hF, 4'hF, 1'b0, 1'b0};
        vecs[2]  = '{1'b0,  4, K_NONE, 4'b1011, 4'hF, 4'hF, 1'b0, 1'b0};
        vecs[3]  = '{1'b0,  8, K_NONE, 4'b1101, 4'hF, 4'hF, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 12, K_NONE, 4'b1110, 4'hF, 4'hF, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 16, K_NONE, 4'b0111, 4'hF, 4'hF, 1'b0, 1'b0};
        vecs[6]  = '{1'b1,  0, K5,     4'b0111, 4'hF, 4'hF, 1'b0, 1'b0};
        vecs[7]  = '{1'b0,  7, K5,     4'b1011, 4'hF, 4'hF, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 12, K5,     4'b1011, 4'hF, 4'hF, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 16, K5,     4'b1011, 4'hF, 4'hF, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 17, K5,     4'b1011, 4'b1011, 4'b1011, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 18, K5,     4'b1011, 4'b1011, 4'b1011, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 40, K_NONE, 4'b1011, 4'b1011, 4'b1011, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 48, K5,     4'b1011, 4'b1011, 4'b1011, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 52, K_NONE, 4'b1011, 4'b1011, 4'b1011, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 63, K_NONE, 4'b1011, 4'b1011, 4'b1011, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 64, K_NONE, 4'b1101, 4'b1011, 4'b1011, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 68, K_NONE, 4'b1110, 4'b1011, 4'b1011, 1'b0, 1'b0};

        // Rotation, key-5 press with latency, and release with a mid-release glitch.
        k  = 0;
        v0 = 0;
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst_first) begin
                @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                k = 0;
                if (i == 6) v0 = vcount;
            end else begin
                while (k < vecs[i].k) begin
                    @(negedge clk);
                    k++;
                end
            end
            check($sformatf("vec%0d", i), {18'd0, key_c, code_c, code_r, key_valid, key_down},
                  {18'd0, vecs[i].kc, vecs[i].cc, vecs[i].cr, vecs[i].v, vecs[i].d});
            keys = vecs[i].keys_after;
            if (vecs[i].rst_first) rst = 1'b0;
        end
        check("press_release_pulses", vcount - v0, 1);

        // Bounce: row low for two ticks only.
        keys = K5;
        apply_reset();
        v0 = vcount;
        repeat (12) @(negedge clk);
        keys = K_NONE;
        repeat (4) @(negedge clk);
        check("bounce_col", {28'd0, key_c}, {28'd0, 4'b1101});
        check("bounce_down", {31'd0, key_down}, 32'd0);
        repeat (4) @(negedge clk);
        check("bounce_col_next", {28'd0, key_c}, {28'd0, 4'b1110});
        repeat (10) @(negedge clk);
        check("bounce_pulses", vcount - v0, 0);

        // Two rows low on one column is never a key.
        keys = K_MULTI;
        apply_reset();
        v0 = vcount;
        repeat (4) @(negedge clk);
        check("multi_col4", {28'd0, key_c}, {28'd0, 4'b1011});
        repeat (156) @(negedge clk);
        check("multi_col160", {28'd0, key_c}, {28'd0, 4'b0111});
        repeat (4) @(negedge clk);
        check("multi_col164", {28'd0, key_c}, {28'd0, 4'b1011});
        check("multi_down", {31'd0, key_down}, 32'd0);
        check("multi_pulses", vcount - v0, 0);
        keys = K_NONE;

        // Reset pulse while pressed with the key still held.
        keys = K5;
        apply_reset();
        repeat (20) @(negedge clk);
        check("held_down", {31'd0, key_down}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pulse_state", {18'd0, key_c, code_c, code_r, key_valid, key_down},
              {18'd0, 4'b0111, 4'hF, 4'hF, 1'b0, 1'b0});
        rst = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1 && lat < 0) lat = i;
        end
        check("rearm_latency", lat, 17);
        check("rearm_code", {24'd0, code_c, code_r}, {24'd0, 4'b1011, 4'b1011});
        keys = K_NONE;

        // Random key activity, occasional multi-key and reset pulses; the model checks each cycle.
        apply_reset();
        for (int seg = 0; seg < 150; seg++) begin
            sel = $urandom_range(0, 99);
            a   = $urandom_range(0, 15);
            b   = $urandom_range(0, 15);
            if (sel < 55)      keys = 16'h0001 << a;
            else if (sel < 70) keys = (16'h0001 << a) | (16'h0001 << b);
            else               keys = K_NONE;
            dur = $urandom_range(1, 50);
            repeat (dur) @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        keys = K_NONE;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
